// File: rtl/lsu_pkg.sv
// Shared FSM state, memword encodings and misalignment decode for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] MW_BYTE = 2'b00;
  localparam logic [1:0] MW_HALF = 2'b01;
  localparam logic [1:0] MW_WORD = 2'b10;

  localparam logic MEMRW_WRITE = 1'b1;

  // The illegal size encoding is refused the same way as a misaligned access.
  function automatic logic misaligned(input logic [1:0] memword, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (memword)
      MW_BYTE: bad = 1'b0;
      MW_HALF: bad = offset[0];
      MW_WORD: bad = |offset;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response plus data-memory bus signals of the load/store unit.
interface lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              memrw;
  logic [1:0]        memword;
  logic              memsign;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic [31:0]       rdata;
  logic              misalign;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0]        dm_be;
  logic [31:0]       dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [31:0]       dm_rdata;

  modport slave (
    input  req, memrw, memword, memsign, addr, wdata, dm_gnt, dm_rvalid, dm_rdata,
    output busy, done, rdata, misalign, dm_req, dm_we, dm_addr, dm_be, dm_wdata
  );

  modport master (
    output req, memrw, memword, memsign, addr, wdata, dm_gnt, dm_rvalid, dm_rdata,
    input  busy, done, rdata, misalign, dm_req, dm_we, dm_addr, dm_be, dm_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store replication, load shift and extension.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow the registered access descriptor.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  memword,
  input  logic        memsign,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] dm_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [15:0] low;

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = dm_rdata;
    low       = 16'(dm_rdata >> {offset, 3'b000});
    case (memword)
      MW_BYTE: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = memsign ? {24'd0, low[7:0]} : {{24{low[7]}}, low[7:0]};
      end
      MW_HALF: begin
        be        = 4'b0011 << offset;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = memsign ? {16'd0, low} : {{16{low[15]}}, low};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = dm_rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one data-memory bus transaction per core LOAD/STORE, aligned load return.
// Latency: store 2 cycles, load 3 cycles minimum; refused (misaligned) access 1 cycle.
// Backpressure: busy stalls the core until done; bus grant/response may be delayed arbitrarily.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  lsu_if.slave  bus
);

  state_e            state_q, state_d;
  logic              memrw_q, memrw_d;
  logic [1:0]        memword_q, memword_d;
  logic              memsign_q, memsign_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              misalign_q, misalign_d;

  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;
  logic        in_req;

  lsu_align u_align (
    .memword   (memword_q),
    .memsign   (memsign_q),
    .offset    (addr_q[1:0]),
    .wdata     (wdata_q),
    .dm_rdata  (bus.dm_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
    state_d    = state_q;
    memrw_d    = memrw_q;
    memword_d  = memword_q;
    memsign_d  = memsign_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          rdata_d = '0;
          if (misaligned(bus.memword, bus.addr[1:0])) begin
            misalign_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            memrw_d   = bus.memrw;
            memword_d = bus.memword;
            memsign_d = bus.memsign;
            addr_d    = bus.addr;
            wdata_d   = bus.wdata;
            state_d   = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus.dm_gnt) begin
          state_d = (memrw_q == MEMRW_WRITE) ? ST_DONE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.dm_rvalid) begin
          rdata_d = rdata_ext;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      memrw_q    <= 1'b0;
      memword_q  <= MW_BYTE;
      memsign_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      memrw_q    <= memrw_d;
      memword_q  <= memword_d;
      memsign_q  <= memsign_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  // Lane enables and write strobe are only meaningful while the request is on the bus.
  assign in_req       = (state_q == ST_REQ);
  assign bus.dm_req   = in_req;
  assign bus.dm_we    = in_req & (memrw_q == MEMRW_WRITE);
  assign bus.dm_be    = in_req ? be : 4'b0000;
  assign bus.dm_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.dm_wdata = wdata_rep;
  assign bus.done     = (state_q == ST_DONE);
  assign bus.misalign = misalign_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = bus.req & ~bus.done;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: table of single transactions plus a mid-response reset sequence.
module tb_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_W(32)) bus ();

  lsu #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    string       name;
    logic        rw;
    logic [1:0]  mw;
    logic        ms;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    int          gd;
    int          rd;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_mis;
    int          e_lat;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, logic rw, logic [1:0] mw, logic ms,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] bd,
                              int gd, int rd, logic [3:0] be, logic [31:0] ea,
                              logic [31:0] ew, logic [31:0] er, logic mis, int lat);
    vec_t v;
    v.name = nm; v.rw = rw; v.mw = mw; v.ms = ms; v.addr = a; v.wdata = wd;
    v.bus_rdata = bd; v.gd = gd; v.rd = rd; v.e_be = be; v.e_addr = ea;
    v.e_wdata = ew; v.e_rdata = er; v.e_mis = mis; v.e_lat = lat;
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    int          lat;
    bit          got, seen, unstable, busy_bad;
    logic [3:0]  be_s;
    logic [31:0] addr_s, wd_s;
    logic        we_s;
    lat = 0; got = 0; seen = 0; unstable = 0; busy_bad = 0;
    be_s = '0; addr_s = '0; wd_s = '0; we_s = 1'b0;
    bus.req = 1'b1; bus.memrw = v.rw; bus.memword = v.mw; bus.memsign = v.ms;
    bus.addr = v.addr; bus.wdata = v.wdata; bus.dm_rdata = v.bus_rdata;
    bus.dm_gnt = 1'b0; bus.dm_rvalid = 1'b0;
    while (!got && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      bus.dm_gnt    = !v.e_mis && (lat == 1 + v.gd);
      bus.dm_rvalid = !v.e_mis && !v.rw && (lat == 2 + v.gd + v.rd);
      @(negedge clk);
      if (bus.dm_req) begin
        if (!seen) begin
          be_s = bus.dm_be; addr_s = bus.dm_addr; wd_s = bus.dm_wdata; we_s = bus.dm_we;
          seen = 1;
        end else if (be_s !== bus.dm_be || addr_s !== bus.dm_addr ||
                     wd_s !== bus.dm_wdata || we_s !== bus.dm_we) begin
          unstable = 1;
        end
      end
      if (bus.done) got = 1;
      else if (!bus.busy) busy_bad = 1;
    end
    chk({v.name, "_done_seen"}, 32'(got), 32'd1);
    chk({v.name, "_latency"}, 32'(lat), 32'(v.e_lat));
    chk({v.name, "_rdata"}, bus.rdata, v.e_rdata);
    chk({v.name, "_misalign"}, 32'(bus.misalign), 32'(v.e_mis));
    chk({v.name, "_busy_before_done"}, 32'(busy_bad), 32'd0);
    chk({v.name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    if (v.e_mis) begin
      chk({v.name, "_no_bus_req"}, 32'(seen), 32'd0);
    end else begin
      chk({v.name, "_dm_be"}, 32'(be_s), 32'(v.e_be));
      chk({v.name, "_dm_addr"}, addr_s, v.e_addr);
      chk({v.name, "_dm_we"}, 32'(we_s), 32'(v.rw));
      chk({v.name, "_dm_stable"}, 32'(unstable), 32'd0);
      if (v.rw) chk({v.name, "_dm_wdata"}, wd_s, v.e_wdata);
    end
    @(posedge clk); #1;
    bus.req = 1'b0; bus.dm_gnt = 1'b0; bus.dm_rvalid = 1'b0;
    @(negedge clk);
    chk({v.name, "_done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  vec_t vt[13];
  vec_t v_after_rst;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit late_done;
    //             name         rw    mw    ms    addr          wdata         bus_rdata    gd rd be       e_addr        e_wdata       e_rdata       mis  lat
    vt[0]  = mk("st_word",     1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 4'b1111, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 2);
    vt[1]  = mk("ld_sbyte",    1'b0, 2'd0, 1'b0, 32'h203, 32'h0,        32'h80000000, 0, 3, 4'b1000, 32'h200, 32'h0,        32'hFFFFFF80, 1'b0, 6);
    vt[2]  = mk("ld_uhalf",    1'b0, 2'd1, 1'b1, 32'h302, 32'h0,        32'h8001ABCD, 0, 0, 4'b1100, 32'h300, 32'h0,        32'h00008001, 1'b0, 3);
    vt[3]  = mk("st_half",     1'b1, 2'd1, 1'b0, 32'h402, 32'h00001234, 32'h0,        0, 0, 4'b1100, 32'h400, 32'h12341234, 32'h0,        1'b0, 2);
    vt[4]  = mk("mis_word",    1'b0, 2'd2, 1'b0, 32'h501, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        32'h0,        1'b1, 1);
    vt[5]  = mk("st_byte",     1'b1, 2'd0, 1'b0, 32'h003, 32'hAABBCC5A, 32'h0,        0, 0, 4'b1000, 32'h000, 32'h5A5A5A5A, 32'h0,        1'b0, 2);
    vt[6]  = mk("ld_word_slow",1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'h12345678, 2, 1, 4'b1111, 32'h010, 32'h0,        32'h12345678, 1'b0, 6);
    vt[7]  = mk("ld_shalf_pos",1'b0, 2'd1, 1'b0, 32'h006, 32'h0,        32'h7FFF9234, 0, 0, 4'b1100, 32'h004, 32'h0,        32'h00007FFF, 1'b0, 3);
    vt[8]  = mk("ld_shalf_neg",1'b0, 2'd1, 1'b0, 32'h008, 32'h0,        32'h12348001, 1, 0, 4'b0011, 32'h008, 32'h0,        32'hFFFF8001, 1'b0, 4);
    vt[9]  = mk("ld_ubyte",    1'b0, 2'd0, 1'b1, 32'h001, 32'h0,        32'h0000F000, 0, 0, 4'b0010, 32'h000, 32'h0,        32'h000000F0, 1'b0, 3);
    vt[10] = mk("mis_half",    1'b1, 2'd1, 1'b0, 32'h007, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        32'h0,        1'b1, 1);
    vt[11] = mk("mis_illegal", 1'b0, 2'd3, 1'b0, 32'h000, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        32'h0,        1'b1, 1);
    vt[12] = mk("st_word_slow",1'b1, 2'd2, 1'b0, 32'h7FC, 32'h01020304, 32'h0,        3, 0, 4'b1111, 32'h7FC, 32'h01020304, 32'h0,        1'b0, 5);
    v_after_rst = mk("ld_after_rst", 1'b0, 2'd0, 1'b0, 32'h601, 32'h0, 32'h00008000, 0, 0, 4'b0010, 32'h600, 32'h0, 32'hFFFFFF80, 1'b0, 3);

    bus.req = 1'b0; bus.memrw = 1'b0; bus.memword = 2'd0; bus.memsign = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.dm_gnt = 1'b0; bus.dm_rvalid = 1'b0; bus.dm_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_dm_req", 32'(bus.dm_req), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_dm_be", 32'(bus.dm_be), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_txn(vt[i]);

    // Reset while a load is waiting in RESP.
    bus.req = 1'b1; bus.memrw = 1'b0; bus.memword = 2'd2; bus.memsign = 1'b0;
    bus.addr = 32'h600; bus.dm_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1; bus.dm_gnt = 1'b1;
    @(posedge clk); #1; bus.dm_gnt = 1'b0;
    @(negedge clk);
    chk("pre_rst_dm_addr", bus.dm_addr, 32'h600);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dm_req", 32'(bus.dm_req), 32'd0);
    chk("rst_dm_we", 32'(bus.dm_we), 32'd0);
    chk("rst_dm_be", 32'(bus.dm_be), 32'd0);
    chk("rst_dm_addr", bus.dm_addr, 32'd0);
    chk("rst_dm_wdata", bus.dm_wdata, 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_misalign", 32'(bus.misalign), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    bus.req = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1; bus.dm_rvalid = 1'b1;
    @(posedge clk); #1; bus.dm_rvalid = 1'b0;
    late_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.done || bus.dm_req) late_done = 1;
    end
    chk("late_rvalid_ignored", 32'(late_done), 32'd0);
    run_txn(v_after_rst);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
